// File: rtl/gouram_trace_pkg.sv
// Shared definitions for the trace serialiser: word-count helper, FSM states
// and drop-counter width.
package gouram_trace_pkg;

    localparam int unsigned DROP_CNT_W = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } tx_state_e;

    function automatic int unsigned calc_wpr(input int unsigned trace_w,
                                             input int unsigned word_w);
        return (trace_w + word_w - 1) / word_w;
    endfunction

endpackage

// File: rtl/trace_record_fifo.sv
// Circular record buffer; exposes the head and the entry behind it so the
// serialiser can roll straight onto the next record without a bubble.
module trace_record_fifo #(
    parameter int unsigned WIDTH = 609,
    parameter int unsigned DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           data_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           head_o,
    output logic [WIDTH-1:0]           head_next_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_i) wr_ptr_d = AW'(wr_ptr_q + 1'b1);
        if (pop_i)  rd_ptr_d = AW'(rd_ptr_q + 1'b1);
        count_d = CW'(count_q + CW'(push_i) - CW'(pop_i));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: occupancy is tracked by the pointers alone.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= data_i;
    end

    assign head_o      = mem_q[rd_ptr_q];
    assign head_next_o = mem_q[AW'(rd_ptr_q + 1'b1)];
    assign count_o     = count_q;
    assign full_o      = (count_q == CW'(DEPTH));
    assign empty_o     = (count_q == '0);

endmodule

// File: rtl/trace_serialiser.sv
// Buffers wide trace records and streams each one out as WORD_WIDTH words
// over a valid/ready interface, counting records lost to a full buffer.
module trace_serialiser
    import gouram_trace_pkg::*;
#(
    parameter int unsigned TRACE_WIDTH = 609,
    parameter int unsigned WORD_WIDTH  = 32,
    parameter int unsigned FIFO_DEPTH  = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   trace_valid_i,
    input  logic [TRACE_WIDTH-1:0] trace_data_i,
    output logic [WORD_WIDTH-1:0]  tdata_o,
    output logic                   tvalid_o,
    input  logic                   tready_i,
    output logic                   tlast_o,
    output logic                   overflow_o,
    output logic [DROP_CNT_W-1:0]  drop_count_o,
    output logic                   busy_o
);

    localparam int unsigned WPR   = calc_wpr(TRACE_WIDTH, WORD_WIDTH);
    localparam int unsigned PAD_W = WPR * WORD_WIDTH;
    localparam int unsigned IDX_W = (WPR > 1) ? $clog2(WPR) : 1;
    localparam int unsigned CW    = $clog2(FIFO_DEPTH) + 1;

    tx_state_e              state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic                   tvalid_q, tvalid_d;
    logic [WORD_WIDTH-1:0]  tdata_q, tdata_d;
    logic                   tlast_q, tlast_d;
    logic                   overflow_q, overflow_d;
    logic [DROP_CNT_W-1:0]  drop_cnt_q, drop_cnt_d;
    logic                   busy_q, busy_d;

    logic                   hs, last_hs, push_req, fifo_push, drop;
    logic [TRACE_WIDTH-1:0] fifo_head, fifo_head_next;
    logic [CW-1:0]          fifo_count, count_next;
    logic                   fifo_full, fifo_empty;

    trace_record_fifo #(
        .WIDTH (TRACE_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (fifo_push),
        .data_i      (trace_data_i),
        .pop_i       (last_hs),
        .head_o      (fifo_head),
        .head_next_o (fifo_head_next),
        .count_o     (fifo_count),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    // Word k of a record, zero-padded above the top record bit.
    function automatic logic [WORD_WIDTH-1:0] word_of(input logic [TRACE_WIDTH-1:0] rec,
                                                      input logic [IDX_W-1:0]       k);
        logic [PAD_W-1:0] pad;
        pad = PAD_W'(rec);
        return pad[int'(k) * WORD_WIDTH +: WORD_WIDTH];
    endfunction

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        tvalid_d   = tvalid_q;
        tdata_d    = tdata_q;
        tlast_d    = tlast_q;
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;

        hs       = tvalid_q && tready_i;
        last_hs  = hs && tlast_q;
        push_req = trace_valid_i && !rst;
        // A slot frees on the same edge the head's last word leaves.
        fifo_push = push_req && (!fifo_full || last_hs);
        drop      = push_req && fifo_full && !last_hs;

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    state_d  = ST_SEND;
                    idx_d    = '0;
                    tvalid_d = 1'b1;
                    tdata_d  = word_of(fifo_head, '0);
                    tlast_d  = (WPR == 1);
                end
            end
            ST_SEND: begin
                if (hs) begin
                    if (tlast_q) begin
                        idx_d = '0;
                        if (fifo_count > CW'(1)) begin
                            tdata_d = word_of(fifo_head_next, '0);
                            tlast_d = (WPR == 1);
                        end else begin
                            state_d  = ST_IDLE;
                            tvalid_d = 1'b0;
                            tlast_d  = 1'b0;
                        end
                    end else begin
                        idx_d   = IDX_W'(idx_q + 1'b1);
                        tdata_d = word_of(fifo_head, idx_d);
                        tlast_d = (idx_d == IDX_W'(WPR - 1));
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (drop) begin
            overflow_d = 1'b1;
            if (drop_cnt_q != '1) drop_cnt_d = DROP_CNT_W'(drop_cnt_q + 1'b1);
        end

        count_next = CW'(fifo_count + CW'(fifo_push) - CW'(last_hs));
        busy_d     = (count_next != '0) || (state_d == ST_SEND);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            tvalid_q   <= 1'b0;
            tdata_q    <= '0;
            tlast_q    <= 1'b0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            tvalid_q   <= tvalid_d;
            tdata_q    <= tdata_d;
            tlast_q    <= tlast_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
            busy_q     <= busy_d;
        end
    end

    assign tdata_o      = tdata_q;
    assign tvalid_o     = tvalid_q;
    assign tlast_o      = tlast_q;
    assign overflow_o   = overflow_q;
    assign drop_count_o = drop_cnt_q;
    assign busy_o       = busy_q;

endmodule

// File: doc/trace_serialiser.md
TRACE_SERIALISER -- requirements
Module: trace_serialiser

Interface
REQ-001 SHALL have parameter TRACE_WIDTH, default 609, meaning width of one trace record from the trace unit.
REQ-002 SHALL have parameter WORD_WIDTH, default 32, meaning output word width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 2, meaning record buffer entries (power of two, >=2).
REQ-004 SHALL have port clk, input, 1, single clock; all logic on rising edge.
REQ-005 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-006 SHALL have port trace_valid_i, input, 1, trace_data_i holds a new record this cycle.
REQ-007 SHALL have port trace_data_i, input, TRACE_WIDTH, trace record from the trace unit.
REQ-008 SHALL have port tdata_o, output, WORD_WIDTH, current output word.
REQ-009 SHALL have port tvalid_o, output, 1, tdata_o valid.
REQ-010 SHALL have port tready_i, input, 1, sink accepts word when high with tvalid_o.
REQ-011 SHALL have port tlast_o, output, 1, current word is the last of its record.
REQ-012 SHALL have port overflow_o, output, 1, sticky flag: at least one record dropped.
REQ-013 SHALL have port drop_count_o, output, 16, number of dropped records, saturating.
REQ-014 SHALL have port busy_o, output, 1, FIFO non-empty or word in flight.

Function
REQ-015 SHALL define WPR = ceil(TRACE_WIDTH/WORD_WIDTH) (20 at defaults); word k SHALL carry record bits [k*WORD_WIDTH +: WORD_WIDTH], zero-padded above TRACE_WIDTH-1 (word 19 carries bit 608 at bit 0, bits 31:1 zero).
REQ-016 SHALL capture trace_data_i into the FIFO on the cycle trace_valid_i is high and FIFO not full; record visible to the FSM no earlier than the next cycle.
REQ-017 SHALL, when trace_valid_i is high and FIFO full, discard the record, set overflow_o, increment drop_count_o (saturating at 0xFFFF).
REQ-018 SHALL treat FIFO as not full on a cycle where the last word of the head record is handshaken, so simultaneous capture and pop at full succeeds without drop.
REQ-019 SHALL implement FSM states IDLE and SEND; IDLE->SEND when FIFO non-empty; SEND stays while words remain; on last-word handshake SEND->SEND if another record present, else ->IDLE.
REQ-020 SHALL assert tvalid_o only in SEND; word index SHALL advance only on tvalid_o && tready_i; tdata_o, tlast_o SHALL stay stable while tvalid_o && !tready_i.
REQ-021 SHALL assert tlast_o exactly when word index == WPR-1; word index wraps to 0 and FIFO head pops on that handshake.
REQ-022 SHALL sustain one word per cycle with tready_i held high, including back-to-back records with no idle cycle between them.
REQ-023 SHALL drive busy_o = FIFO non-empty or state == SEND.

Reset
REQ-024 SHALL, on rst high at a clock edge, set state IDLE, word index 0, FIFO empty, tvalid_o 0, tlast_o 0, tdata_o 0, overflow_o 0, drop_count_o 0, busy_o 0.
REQ-025 SHALL abort any partially sent record on reset mid-operation; no word of it is re-sent after reset.
REQ-026 SHALL ignore trace_valid_i on cycles where rst is high.

Structure
REQ-027 SHALL place WPR computation, state enumeration and drop-counter width in shared package gouram_trace_pkg.
REQ-028 SHALL implement the record buffer as sub-module trace_record_fifo (push/pop/full/empty, TRACE_WIDTH x FIFO_DEPTH).
REQ-029 SHALL select output word with an indexed part-select from the FIFO head; no full-record shift register.

Verification
REQ-030 One record bits[31:0]=0xDEADBEEF, bit 608=1, tready_i=1 -> 20 words on consecutive cycles starting 2 cycles after capture, word0=0xDEADBEEF, word19=0x00000001 with tlast_o=1.
REQ-031 tready_i low on word 5 for 3 cycles -> tdata_o/tlast_o unchanged over those cycles, total 20 handshakes, no duplicated or skipped word.
REQ-032 tready_i=0, three records pushed on consecutive cycles -> first two buffered, third dropped, overflow_o=1, drop_count_o=1.
REQ-033 FIFO full, new record on same cycle as head last-word handshake -> record accepted, drop_count_o stays 0.
REQ-034 rst asserted at word 7 of a record -> next cycle tvalid_o=0, busy_o=0, drop_count_o=0; next record sends from word 0.
REQ-035 65540 records pushed with tready_i=0 -> drop_count_o saturates at 0xFFFF, overflow_o=1.
